// File: rtl/onehot_demux_pkg.sv
// Shared constants and one-hot helpers for the one-hot stream demux.
// Holds the drop counter width and the select decode functions.
// Selects are zero-extended to 32 bits, the widest channel count supported.
package onehot_demux_pkg;

    localparam int DROP_CNT_W = 8;
    localparam int SEL_MAX_W  = 32;

    // True when exactly one bit is set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    // Bit position of the set bit; only meaningful when is_onehot(v) holds.
    function automatic int onehot_index(input logic [SEL_MAX_W-1:0] v);
        int idx;
        idx = 0;
        for (int k = 0; k < SEL_MAX_W; k++) begin
            if (v[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Latency: load to out_valid is 1 cycle; load and drain on the same edge keeps the slot full.
// Backpressure: holds data stable while out_valid && !out_ready; the parent gates load.
// Ports: load/load_data write the slot, out_ready drains it, out_valid/out_data present it.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // A load on the draining edge overrides the clear.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/onehot_demux_stream.sv
// Routes a valid/ready input stream to one of N one-entry output slots by one-hot select.
// Latency: 1 cycle from acceptance to out_valid; one beat per cycle per channel.
// Backpressure: in_ready follows the selected slot; illegal selects are always accepted and dropped.
// Ports: clk/rst_n; in_valid/in_ready/in_data/in_sel; out_valid/out_ready/out_data[N];
//        err_sel pulses one cycle per dropped beat; drop_cnt saturates at 255.
module onehot_demux_stream
    import onehot_demux_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_data,
    input  logic [N-1:0]          in_sel,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [W-1:0]          out_data [N],
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [SEL_MAX_W-1:0]  sel_ext;
    logic                  sel_legal;
    logic [IDX_W-1:0]      sel_idx;
    logic                  accept;
    logic                  drop;
    logic [N-1:0]          load;

    logic                  err_sel_q,  err_sel_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign sel_ext   = SEL_MAX_W'(in_sel);
    assign sel_legal = is_onehot(sel_ext);
    assign sel_idx   = IDX_W'(onehot_index(sel_ext));

    // Held low during reset so no beat is accepted while slots are being cleared.
    assign in_ready = rst_n && (!in_valid || !sel_legal ||
                                !out_valid[sel_idx] || out_ready[sel_idx]);
    assign accept   = in_valid && in_ready;
    assign drop     = accept && !sel_legal;
    assign load     = (accept && sel_legal) ? in_sel : '0;

    for (genvar g = 0; g < N; g++) begin : g_slot
        demux_slot #(
            .W (W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g])
        );
    end

    always_comb begin
        err_sel_d  = drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_onehot_demux_stream.sv
// Self-checking bench for onehot_demux_stream (N=8, W=8).
// Table vectors, directed multi-cycle sequences, then randomized traffic against a queue model.
// Inputs change 1 ns after the rising edge; outputs are sampled before the next edge.
module tb_onehot_demux_stream;
    import onehot_demux_pkg::*;

    localparam int N = 8;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [N-1:0] in_sel;
    logic [N-1:0] out_valid;
    logic [N-1:0] out_ready;
    logic [W-1:0] out_data [N];
    logic         err_sel;
    logic [7:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_demux_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic         v;
        logic [N-1:0] sel;
        logic [W-1:0] dat;
        logic [N-1:0] rdy;
        logic         exp_in_rdy;
        logic [N-1:0] exp_ovld;
        logic         exp_err;
        logic [7:0]   exp_cnt;
        logic         chk_dat;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [N-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: per-channel queue of beats accepted but not yet drained.
    logic [W-1:0] exp_q [N][$];

    initial begin
        int           beats;
        int           left;
        int           ch;
        logic         v;
        logic [N-1:0] r;
        logic [N-1:0] s;
        logic [W-1:0] d;
        logic [W-1:0] e;
        logic [N-1:0] exp_ovld;

        // Scenario 1 rows, then idle and the illegal-select rows of scenario 3.
        for (int k = 0; k < 8; k++) begin
            vecs[k] = '{1'b1, N'(1 << k), W'(8'h11 + k), 8'hFF, 1'b1, N'(1 << k), 1'b0, 8'd0, 1'b1};
        end
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd0, 1'b0};
        vecs[9]  = '{1'b1, 8'h00, 8'h33, 8'hFF, 1'b1, 8'h00, 1'b1, 8'd1, 1'b0};
        vecs[10] = '{1'b1, 8'h06, 8'h44, 8'hFF, 1'b1, 8'h00, 1'b1, 8'd2, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 8'd2, 1'b0};

        // Reset state, with a beat offered so in_ready low is meaningful.
        rst_n = 1'b0;
        drive(1'b1, 8'h01, 8'hEE, 8'hFF);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset err_sel", err_sel, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_data0", out_data[0], 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("post-reset out_valid", out_valid, 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].sel, vecs[i].dat, vecs[i].rdy);
            chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_in_rdy);
            tick();
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_ovld);
            chk($sformatf("vec%0d err_sel", i), err_sel, vecs[i].exp_err);
            chk($sformatf("vec%0d drop_cnt", i), drop_cnt, vecs[i].exp_cnt);
            if (vecs[i].chk_dat) begin
                chk($sformatf("vec%0d out_data", i),
                    out_data[onehot_index(32'(vecs[i].sel))], vecs[i].dat);
            end
        end

        // Scenario 2: backpressure on channel 3, then load on the draining edge.
        drive(1'b1, 8'h08, 8'hA5, 8'hF7);
        chk("s2 first in_ready", in_ready, 1);
        tick();
        chk("s2 ch3 valid", out_valid, 8'h08);
        chk("s2 ch3 data A5", out_data[3], 8'hA5);
        drive(1'b1, 8'h08, 8'h5A, 8'hF7);
        chk("s2 second in_ready", in_ready, 0);
        tick();
        chk("s2 ch3 held valid", out_valid, 8'h08);
        chk("s2 ch3 held data", out_data[3], 8'hA5);
        drive(1'b1, 8'h08, 8'h5A, 8'hFF);
        chk("s2 drain in_ready", in_ready, 1);
        tick();
        chk("s2 ch3 reload valid", out_valid, 8'h08);
        chk("s2 ch3 data 5A", out_data[3], 8'h5A);
        drive(1'b0, 8'h00, 8'h00, 8'hFF);
        tick();
        chk("s2 ch3 drained", out_valid, 8'h00);

        // Scenario 4: 300 illegal beats saturate the drop counter (starting from 2).
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, (k % 2 == 0) ? 8'h00 : 8'hC3, W'(k), 8'hFF);
            tick();
            if (k == 252) begin
                chk("s4 drop_cnt reaches 255", drop_cnt, 8'd255);
            end
        end
        chk("s4 drop_cnt holds", drop_cnt, 8'd255);
        chk("s4 err_sel last", err_sel, 1);
        chk("s4 no out_valid", out_valid, 0);
        drive(1'b0, 8'h00, 8'h00, 8'hFF);
        tick();
        chk("s4 err_sel clears", err_sel, 0);
        chk("s4 drop_cnt idle", drop_cnt, 8'd255);

        // Scenario 5: reset asserted mid-cycle with slots 2 and 5 full.
        drive(1'b1, 8'h04, 8'h55, 8'h00);
        tick();
        drive(1'b1, 8'h20, 8'h66, 8'h00);
        tick();
        chk("s5 slots full", out_valid, 8'h24);
        drive(1'b1, 8'h04, 8'h99, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5 async out_valid", out_valid, 0);
        chk("s5 async drop_cnt", drop_cnt, 0);
        chk("s5 async out_data2", out_data[2], 0);
        chk("s5 in_ready in reset", in_ready, 0);
        tick();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("s5 no stale valid", out_valid, 0);
        drive(1'b1, 8'h04, 8'h77, 8'hFF);
        chk("s5 in_ready", in_ready, 1);
        chk("s5 not yet valid", out_valid, 0);
        tick();
        chk("s5 ch2 valid", out_valid, 8'h04);
        chk("s5 ch2 data", out_data[2], 8'h77);
        drive(1'b0, 8'h00, 8'h00, 8'hFF);
        tick();
        chk("s5 ch2 drained", out_valid, 0);

        // Scenario 6: random legal traffic against the per-channel queue model.
        beats = 0;
        for (int cyc = 0; cyc < 60000 && beats < 10000; cyc++) begin
            r  = N'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            ch = $urandom_range(0, N - 1);
            s  = N'(1) << ch;
            d  = W'($urandom);
            drive(v, s, d, r);
            for (int c = 0; c < N; c++) begin
                exp_ovld[c] = (exp_q[c].size() != 0);
            end
            chk("rand out_valid", out_valid, exp_ovld);
            chk("rand in_ready", in_ready, !v || exp_q[ch].size() == 0 || r[ch]);
            for (int c = 0; c < N; c++) begin
                if (out_valid[c] && r[c] && exp_q[c].size() != 0) begin
                    e = exp_q[c].pop_front();
                    chk($sformatf("rand ch%0d data", c), out_data[c], e);
                end
            end
            if (v && in_ready) begin
                exp_q[onehot_index(32'(s))].push_back(d);
                beats++;
            end
            tick();
        end
        chk("rand beats sent", beats >= 10000, 1);

        drive(1'b0, 8'h00, 8'h00, 8'hFF);
        for (int c = 0; c < N; c++) begin
            if (out_valid[c] && exp_q[c].size() != 0) begin
                e = exp_q[c].pop_front();
                chk($sformatf("final ch%0d data", c), out_data[c], e);
            end
        end
        tick();
        left = 0;
        for (int c = 0; c < N; c++) begin
            left += exp_q[c].size();
        end
        chk("final model empty", left, 0);
        chk("final out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
